// File: rtl/imem_arbiter.sv
// Single-port instruction memory shared by the CPU fetch port (read-only) and a
// host/loader port (read/write). One access per cycle, round-robin on ties, and a host lock.
module imem_arbiter #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic [AW-1:0]      cpu_addr,
  output logic               cpu_gnt,
  output logic               cpu_rvalid,
  output logic [DW-1:0]      cpu_rdata,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [AW-1:0]      host_addr,
  input  logic [DW-1:0]      host_wdata,
  output logic               host_gnt,
  output logic               host_rvalid,
  output logic [DW-1:0]      host_rdata,
  input  logic               host_lock,
  output logic [STALL_W-1:0] cpu_stall_cnt
);

  typedef enum logic {PRI_CPU = 1'b0, PRI_HOST = 1'b1} pri_e;

  pri_e pri_q, pri_d;

  logic [DW-1:0]      mem [DEPTH];
  logic               cpu_in_range, host_in_range;
  logic [DW-1:0]      cpu_word, host_word;
  logic               host_rd_p0;
  logic               cpu_rvalid_p1, host_rvalid_p1;
  logic [DW-1:0]      cpu_rdata_p1, host_rdata_p1;
  logic [STALL_W-1:0] stall_p1;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Out-of-range decode only exists when the address space is larger than the array.
  if (DEPTH >= (1 << AW)) begin : g_full_map
    assign cpu_in_range  = 1'b1;
    assign host_in_range = 1'b1;
  end else begin : g_partial_map
    assign cpu_in_range  = (cpu_addr  < AW'(DEPTH));
    assign host_in_range = (host_addr < AW'(DEPTH));
  end

  assign cpu_word   = cpu_in_range  ? mem[cpu_addr]  : '0;
  assign host_word  = host_in_range ? mem[host_addr] : '0;
  assign host_rd_p0 = host_gnt && !host_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pri_q <= PRI_CPU;
    else        pri_q <= pri_d;
  end

  always_comb begin
    pri_d = pri_q;
    if (cpu_gnt)       pri_d = PRI_HOST;
    else if (host_gnt) pri_d = PRI_CPU;
  end

  // Grants are gated by rst_n so nothing is accepted while reset is asserted.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (rst_n) begin
      if (host_lock) begin
        host_gnt = host_req;
      end else if (cpu_req && host_req) begin
        if (pri_q == PRI_CPU) cpu_gnt  = 1'b1;
        else                  host_gnt = 1'b1;
      end else begin
        cpu_gnt  = cpu_req;
        host_gnt = host_req;
      end
    end
  end

  // Memory array has no reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (host_gnt && host_we && host_in_range) mem[host_addr] <= host_wdata;
  end

  // ---- p0 -> p1: registered read return and stall accounting ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid_p1  <= 1'b0;
      host_rvalid_p1 <= 1'b0;
      cpu_rdata_p1   <= '0;
      host_rdata_p1  <= '0;
      stall_p1       <= '0;
    end else begin
      cpu_rvalid_p1  <= cpu_gnt;
      host_rvalid_p1 <= host_rd_p0;
      if (cpu_gnt)    cpu_rdata_p1  <= cpu_word;
      if (host_rd_p0) host_rdata_p1 <= host_word;
      if (cpu_req && !cpu_gnt) stall_p1 <= sat_inc(stall_p1);
    end
  end

  assign cpu_rvalid    = cpu_rvalid_p1;
  assign cpu_rdata     = cpu_rdata_p1;
  assign host_rvalid   = host_rvalid_p1;
  assign host_rdata    = host_rdata_p1;
  assign cpu_stall_cnt = stall_p1;

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Owns the single-port instruction memory used by the mini CPU core.
- Arbitrates that memory between two requesters: the CPU fetch port (read-only) and a host/loader port (read/write), with one access per cycle.
- Host can lock out the CPU during program load. Counts CPU stall cycles for performance debug.
- Sits between the core's FETCH logic and the test/boot loader.

Parameters:
- DEPTH, 16, number of memory words.
- AW, 4, address width; must satisfy 2^AW >= DEPTH.
- DW, 8, data word width.
- STALL_W, 8, width of the saturating CPU stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU read request; held until granted.
- cpu_addr  input  AW  CPU read address; stable while cpu_req=1.
- cpu_gnt  output  1  CPU access accepted this cycle (combinational).
- cpu_rvalid  output  1  cpu_rdata valid (registered).
- cpu_rdata  output  DW  CPU read data.
- host_req  input  1  host request; held until granted.
- host_we  input  1  1 = write, 0 = read.
- host_addr  input  AW  host address.
- host_wdata  input  DW  host write data.
- host_gnt  output  1  host access accepted this cycle (combinational).
- host_rvalid  output  1  host_rdata valid (registered, reads only).
- host_rdata  output  DW  host read data.
- host_lock  input  1  1 = CPU is never granted.
- cpu_stall_cnt  output  STALL_W  saturating count of CPU wait cycles.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: cpu_rvalid=0, host_rvalid=0, cpu_rdata=0, host_rdata=0, cpu_stall_cnt=0, priority state=PRI_CPU.
- While rst_n=0, cpu_gnt=0 and host_gnt=0.
- Memory array is not reset; its contents survive rst_n assertion.

Priority state machine (round-robin pointer):
- PRI_CPU: CPU wins a tie.
- PRI_HOST: host wins a tie.
- After any cycle in which cpu_gnt=1, next state is PRI_HOST.
- After any cycle in which host_gnt=1, next state is PRI_CPU.
- With no grant, state holds.

Grant rules (combinational from current inputs and state; at most one grant per cycle):
- host_lock=1: cpu_gnt=0; host_gnt=host_req.
- Only one requester active: that requester is granted.
- Both active: the requester named by the state is granted.

Access timing:
- Access is performed at the rising edge where its grant is high.
- Read: rdata and rvalid are registered, so data appears the cycle after the grant (latency 1). rvalid is a 1-cycle pulse; rdata holds its last value afterwards.
- Write (host_we=1): the memory word updates at the grant edge. host_rvalid stays 0.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data.

Addresses:
- addr >= DEPTH: write is dropped; read returns 0 with rvalid still pulsed.

Handshake:
- A requester must keep req, addr, we and wdata stable until its grant.
- Dropping req before the grant is legal and cancels the request; there is no side effect.

Stall counter:
- Increments by 1 on each edge where cpu_req=1 and cpu_gnt=0, including cycles locked out by host_lock.
- Saturates at 2^STALL_W-1. Cleared only by reset.

Reset mid-operation:
- In-flight rvalid is killed.
- A write whose grant edge coincides with rst_n low does not occur.

Test Plan:
- Host writes 0xA5 to addr 3, then the CPU reads addr 3 → cpu_gnt same cycle as req; next cycle cpu_rvalid=1, cpu_rdata=0xA5; host_rvalid stays 0 throughout.
- From reset, cpu_req and host_req both held high with host reads → grants alternate CPU, host, CPU, host; each rvalid lags its grant by 1 cycle; cpu_stall_cnt=2 after 4 cycles.
- host_lock=1 for 5 cycles with cpu_req=1 → cpu_gnt=0 all 5 cycles; cpu_stall_cnt=5. Release lock with host_req=0 → CPU granted the next cycle.
- Host write to addr 7 in cycle N, CPU read of addr 7 granted in cycle N+1 → cpu_rdata equals the new value in cycle N+2.
- Set DEPTH=12. Host writes 0xFF to addr 13, then reads addr 13 → host_rvalid=1, host_rdata=0x00.
- Hold cpu_req=1 with host_lock=1 for 300 cycles, STALL_W=8 → counter stops at 255. Then pulse rst_n low mid-read → rvalids drop immediately, counter=0, previously written memory data still readable after reset.
